addr_decoder_cfg_loader: RTL and testbench
==========================================

Name: addr_decoder_cfg_loader

Overview:
Host-side initiator for the address-decoder configuration byte-write port. It receives framed configuration records as a byte stream over a valid/ready handshake and buffers each frame's payload. It checks the frame's checksum and range, then replays the payload as back-to-back cfg_we/cfg_addr/cfg_wdata strobes into the window BASE/MASK/SLOT/OP table storage. A bad frame produces no writes.

Parameters:
ADDR_W, 32, decoder address width; sets CFG_BYTES = ceil(ADDR_W/8).
NUM_WIN, 16, number of decode windows; sets CFG_SIZE = NUM_WIN*(2*CFG_BYTES+2), which is 160 at the defaults.
DEPTH, 16, maximum payload bytes per frame (frame buffer depth).
TIMEOUT_CYC, 1024, idle cycles allowed between bytes inside a frame.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
cfg_clk  in  1  sole clock.
cfg_rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  stream byte valid.
in_ready  out  1  loader accepts a byte; a transfer happens when in_valid && in_ready.
in_data  in  8  stream byte.
cfg_we  out  1  config write strobe, one byte per cycle.
cfg_addr  out  8  config byte address.
cfg_wdata  out  8  config write data.
busy  out  1  high in every state except S_IDLE.
frame_ok  out  1  one-cycle pulse when a frame has committed.
frame_err  out  1  one-cycle pulse when a frame is rejected.
err_code  out  2  held until the next frame_ok/frame_err: 0 none, 1 checksum, 2 length/range, 3 timeout.

Behaviour:
- Frame format: SYNC, ADDR, LEN, LEN data bytes, CHK.
  - The frame is good when (ADDR + LEN + sum(data) + CHK) mod 256 == 0.
  - LEN = 0 is legal: no data bytes, no writes.
- Reset values: in_ready=0 while reset is asserted, then 1 in S_IDLE. cfg_we=0, cfg_addr=0, cfg_wdata=0, busy=0, frame_ok=0, frame_err=0, err_code=0. State returns to S_IDLE.
- Reset mid-frame or mid-commit aborts at once. cfg_we drops asynchronously and buffered bytes are discarded.
- States:
  - S_IDLE: bytes other than SYNC_BYTE are accepted and dropped. SYNC_BYTE → S_ADDR.
  - S_ADDR: latch the start address and seed the running sum with it → S_LEN.
  - S_LEN: latch LEN and add it to the sum. Set the discard flag if LEN > DEPTH or ADDR+LEN > CFG_SIZE (9-bit compare, no wrap). LEN = 0 → S_CHK, otherwise → S_DATA.
  - S_DATA: each byte is added to the sum. It is written to buf[cnt] only when the discard flag is clear, so oversize frames are drained without overflowing the buffer. After byte LEN → S_CHK.
  - S_CHK: add CHK to the sum.
    - Discard flag set → S_DONE with err_code 2.
    - Sum ≠ 0 → S_DONE with err_code 1.
    - Otherwise → S_COMMIT, or straight to S_DONE with OK when LEN = 0.
  - S_COMMIT: in_ready=0. For i = 0..LEN-1 on consecutive cycles drive cfg_we=1, cfg_addr=ADDR+i, cfg_wdata=buf[i].
    - The first strobe is in the cycle after the CHK handshake.
    - After the last strobe → S_DONE.
  - S_DONE: one cycle. Pulse frame_ok or frame_err, update err_code, in_ready=0 → S_IDLE.
- Timeout: in S_ADDR, S_LEN, S_DATA and S_CHK, a counter restarts on every accepted byte.
  - At TIMEOUT_CYC consecutive cycles without a byte → S_DONE with err_code 3.
  - Bytes arriving afterwards are hunted for SYNC as usual.
- in_ready is 1 in S_IDLE through S_CHK and 0 in S_COMMIT and S_DONE. Upstream must hold in_valid/in_data stable while not ready.
- A SYNC_BYTE value inside the data is payload, not a resync.
- cfg_addr never wraps, because the range check guarantees ADDR+LEN ≤ CFG_SIZE ≤ 256.
- cfg_we is never asserted outside S_COMMIT. cfg_addr and cfg_wdata hold their last values when cfg_we=0.

Decomposition:
- Package addr_decoder_cfg_pkg holds:
  - function cfg_bytes(ADDR_W) and function cfg_size(ADDR_W, NUM_WIN);
  - BASE/MASK/SLOT/OP offset constants, so the storage block and the loader share one layout;
  - state enum ld_state_e;
  - err_code constants ERR_NONE/ERR_CHK/ERR_RANGE/ERR_TIMEOUT.
- Sub-module cfg_frame_buf: DEPTH×8 register buffer with write pointer, read pointer and clear. The loader FSM, checksum and timeout logic stay in the top.

Test Plan:
- Good frame: A5 00 04 11 22 33 44 52 → cfg_we high for 4 consecutive cycles, addr 00..03, data 11,22,33,44. First strobe one cycle after CHK. frame_ok pulses the next cycle, err_code=0.
- Bad checksum: A5 00 04 11 22 33 44 53 → no cfg_we, frame_err pulse, err_code=1. A following good frame commits normally.
- Range/length:
  - A5 9E 04 + 4 bytes + valid CHK → all bytes consumed, no writes, err_code=2.
  - LEN=17 with 17 bytes + valid CHK → err_code=2.
- Timeout and resync: A5 00 then 1024 idle cycles → frame_err, err_code=3, busy=0. Then 00 FF A5 10 00 F0 (leading bytes dropped; LEN=0 frame) → frame_ok, no cfg_we.
- Backpressure: hold in_valid through a 16-byte commit → in_ready=0 for 16 strobe cycles plus the S_DONE cycle, and no bytes are lost.
- Reset mid-commit: assert cfg_rst_n=0 during the 2nd strobe → cfg_we=0 immediately, no pulses, S_IDLE after release.

Source files
------------

// File: rtl/addr_decoder_cfg_pkg.sv
// Shared layout, state encoding and status codes for the decoder config loader.
// Pure declarations: no latency, no flow control.
package addr_decoder_cfg_pkg;

    function automatic int cfg_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

    // One window record is BASE (CFG_BYTES), MASK (CFG_BYTES), SLOT (1), OP (1).
    function automatic int win_stride(input int addr_w);
        return 2 * cfg_bytes(addr_w) + 2;
    endfunction

    function automatic int cfg_size(input int addr_w, input int num_win);
        return num_win * win_stride(addr_w);
    endfunction

    localparam int WIN_BASE_OFF = 0;

    function automatic int win_mask_off(input int addr_w);
        return cfg_bytes(addr_w);
    endfunction

    function automatic int win_slot_off(input int addr_w);
        return 2 * cfg_bytes(addr_w);
    endfunction

    function automatic int win_op_off(input int addr_w);
        return 2 * cfg_bytes(addr_w) + 1;
    endfunction

    function automatic int win_addr(input int addr_w, input int win, input int field_off);
        return win * win_stride(addr_w) + field_off;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_COMMIT = 3'd5,
        S_DONE   = 3'd6
    } ld_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/cfg_frame_buf.sv
// Frame payload buffer: DEPTH x 8 registers, sequential write and read pointers.
// Write takes effect next cycle; read data is combinational at the read pointer; no flow control.
module cfg_frame_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_dat_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_dat_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset: stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/addr_decoder_cfg_loader.sv
// Framed byte-stream loader: validates SYNC/ADDR/LEN/data/CHK frames, then replays payload as cfg byte writes.
// Commit starts the cycle after CHK, one byte per cycle; in_ready is dropped during commit and the done cycle.
module addr_decoder_cfg_loader
    import addr_decoder_cfg_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         NUM_WIN     = 16,
    parameter int         DEPTH       = 16,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic       cfg_clk,
    input  logic       cfg_rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       cfg_we,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int         CFG_SIZE   = cfg_size(ADDR_W, NUM_WIN);
    localparam logic [8:0] CFG_SIZE_W = 9'(CFG_SIZE);
    localparam logic [8:0] DEPTH_W    = 9'(DEPTH);
    localparam int         TMO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    ld_state_e        state_q;
    logic             in_ready_q;
    logic [7:0]       addr_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [7:0]       sum_q;
    logic             discard_q;
    logic [TMO_W-1:0] tmo_q;
    logic             cfg_we_q;
    logic [7:0]       cfg_addr_q;
    logic [7:0]       cfg_wdata_q;
    logic             frame_ok_q;
    logic             frame_err_q;
    logic [1:0]       err_code_q;

    logic       xfer;
    logic       in_frame;
    logic [7:0] sum_d;
    logic       range_bad_d;
    logic       chk_good_d;
    logic       buf_clr;
    logic       buf_wr;
    logic       buf_rd;
    logic [7:0] buf_rd_dat;

    assign xfer     = in_valid && in_ready_q;
    assign in_frame = state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK};
    assign sum_d    = sum_q + in_data;

    // 9-bit sums so ADDR+LEN cannot wrap past the table size unnoticed.
    assign range_bad_d = ({1'b0, in_data} > DEPTH_W) ||
                         (({1'b0, addr_q} + {1'b0, in_data}) > CFG_SIZE_W);

    assign chk_good_d = !discard_q && (sum_d == 8'd0);

    always_comb begin
        buf_clr = (state_q == S_IDLE);
        buf_wr  = xfer && (state_q == S_DATA) && !discard_q;
        buf_rd  = 1'b0;
        if (state_q == S_CHK && xfer && chk_good_d && len_q != 8'd0) buf_rd = 1'b1;
        if (state_q == S_COMMIT && cnt_q != len_q)                   buf_rd = 1'b1;
    end

    cfg_frame_buf #(
        .DEPTH(DEPTH)
    ) u_frame_buf (
        .clk_i    (cfg_clk),
        .rst_n_i  (cfg_rst_n),
        .clr_i    (buf_clr),
        .wr_en_i  (buf_wr),
        .wr_dat_i (in_data),
        .rd_en_i  (buf_rd),
        .rd_dat_o (buf_rd_dat)
    );

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            addr_q      <= 8'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            sum_q       <= 8'd0;
            discard_q   <= 1'b0;
            tmo_q       <= '0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= 8'd0;
            cfg_wdata_q <= 8'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // Inter-byte watchdog; the state branches below only act on accepted bytes.
            if (in_frame) begin
                if (xfer) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_q     <= S_DONE;
                    in_ready_q  <= 1'b0;
                    frame_err_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    tmo_q      <= '0;
                    if (xfer && in_data == SYNC_BYTE) state_q <= S_ADDR;
                end
                S_ADDR: begin
                    if (xfer) begin
                        addr_q  <= in_data;
                        sum_q   <= in_data;
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_q     <= in_data;
                        sum_q     <= sum_d;
                        discard_q <= range_bad_d;
                        cnt_q     <= 8'd0;
                        state_q   <= (in_data == 8'd0) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum_q <= sum_d;
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q) state_q <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (discard_q) begin
                            state_q     <= S_DONE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_RANGE;
                        end else if (sum_d != 8'd0) begin
                            state_q     <= S_DONE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end else if (len_q == 8'd0) begin
                            state_q    <= S_DONE;
                            frame_ok_q <= 1'b1;
                            err_code_q <= ERR_NONE;
                        end else begin
                            state_q     <= S_COMMIT;
                            cfg_we_q    <= 1'b1;
                            cfg_addr_q  <= addr_q;
                            cfg_wdata_q <= buf_rd_dat;
                            cnt_q       <= 8'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (cnt_q == len_q) begin
                        cfg_we_q   <= 1'b0;
                        state_q    <= S_DONE;
                        frame_ok_q <= 1'b1;
                        err_code_q <= ERR_NONE;
                    end else begin
                        cfg_we_q    <= 1'b1;
                        cfg_addr_q  <= addr_q + cnt_q;
                        cfg_wdata_q <= buf_rd_dat;
                        cnt_q       <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    cfg_we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign cfg_we    = cfg_we_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_addr_decoder_cfg_loader.sv
// Directed bench for addr_decoder_cfg_loader: hand-computed frames, strobe log and status pulses.
module tb_addr_decoder_cfg_loader;

    logic       cfg_clk = 1'b0;
    logic       cfg_rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    addr_decoder_cfg_loader dut (
        .cfg_clk   (cfg_clk),
        .cfg_rst_n (cfg_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 cfg_clk = ~cfg_clk;

    typedef logic [7:0] bq_t[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   ok_cnt = 0;
    int   err_cnt = 0;
    int   stall_cnt = 0;
    bq_t  wa;
    bq_t  wd;
    bq_t  fb;

    always @(negedge cfg_clk) begin
        if (cfg_we) begin
            wa.push_back(cfg_addr);
            wd.push_back(cfg_wdata);
        end
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (in_valid && !in_ready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake, in_valid left high.
    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 64 && !got; k++) begin
            got = in_ready;
            @(negedge cfg_clk);
        end
        if (!got) check("in_ready_wait", 32'(got), 1);
    endtask

    task automatic send_bytes(input bq_t bs);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!(frame_ok || frame_err) && n < 200) begin
            @(negedge cfg_clk);
            n++;
        end
        if (n >= 200) check("frame_wait", 32'(frame_ok | frame_err), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d4[4];
        int n;
        int snap_ok;
        int snap_err;
        d4 = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        repeat (3) @(negedge cfg_clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_cfg_we", cfg_we, 0);
        check("rst_cfg_addr", cfg_addr, 0);
        check("rst_cfg_wdata", cfg_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        cfg_rst_n = 1'b1;
        @(negedge cfg_clk);
        check("idle_in_ready", in_ready, 1);

        // Good frame: first strobe right after CHK, then frame_ok
        wa.delete(); wd.delete();
        fb = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(fb);
        send_byte(8'h52);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("good_we", cfg_we, 1);
            check("good_addr", cfg_addr, 32'(i));
            check("good_wdata", cfg_wdata, d4[i]);
            check("good_commit_rdy", in_ready, 0);
            @(negedge cfg_clk);
        end
        check("good_we_off", cfg_we, 0);
        check("good_ok", frame_ok, 1);
        check("good_errc", err_code, 0);
        check("good_busy_done", busy, 1);
        @(negedge cfg_clk);
        check("good_ok_pulse", frame_ok, 0);
        check("good_busy_idle", busy, 0);
        check("good_nwr", 32'(wa.size()), 4);

        // Bad checksum, then a good frame
        wa.delete(); wd.delete();
        fb = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(fb);
        send_byte(8'h53);
        in_valid = 1'b0;
        check("badchk_err", frame_err, 1);
        check("badchk_ok", frame_ok, 0);
        check("badchk_code", err_code, 1);
        check("badchk_we", cfg_we, 0);
        @(negedge cfg_clk);
        check("badchk_nwr", 32'(wa.size()), 0);
        fb = '{8'hA5, 8'h05, 8'h02, 8'hAB, 8'hCD, 8'h81};
        send_bytes(fb);
        in_valid = 1'b0;
        wait_frame();
        check("after_bad_ok", frame_ok, 1);
        check("after_bad_code", err_code, 0);
        check("after_bad_nwr", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            check("after_bad_a0", wa[0], 8'h05);
            check("after_bad_d0", wd[0], 8'hAB);
            check("after_bad_a1", wa[1], 8'h06);
            check("after_bad_d1", wd[1], 8'hCD);
        end

        // Range: ADDR+LEN beyond table, then LEN beyond buffer depth
        wa.delete(); wd.delete();
        fb = '{8'hA5, 8'h9E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(fb);
        send_byte(8'h54);
        in_valid = 1'b0;
        check("range_err", frame_err, 1);
        check("range_code", err_code, 2);
        fb = '{8'hA5, 8'h00, 8'h11};
        for (int i = 0; i < 17; i++) fb.push_back(8'h01);
        send_bytes(fb);
        send_byte(8'hDE);
        in_valid = 1'b0;
        check("len17_err", frame_err, 1);
        check("len17_code", err_code, 2);
        @(negedge cfg_clk);
        check("range_nwr", 32'(wa.size()), 0);
        check("range_busy", busy, 0);

        // Timeout after ADDR, then resync through junk to a LEN=0 frame
        fb = '{8'hA5, 8'h00};
        send_bytes(fb);
        in_valid = 1'b0;
        n = 0;
        while (!frame_err && n < 1100) begin
            @(negedge cfg_clk);
            n++;
        end
        check("tmo_cycles", 32'(n), 1024);
        check("tmo_code", err_code, 3);
        @(negedge cfg_clk);
        check("tmo_busy", busy, 0);
        fb = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h00, 8'hF0};
        send_bytes(fb);
        in_valid = 1'b0;
        check("len0_ok", frame_ok, 1);
        check("len0_code", err_code, 0);
        check("len0_nwr", 32'(wa.size()), 0);

        // SYNC value inside the payload is data
        wa.delete(); wd.delete();
        fb = '{8'hA5, 8'h30, 8'h02, 8'hA5, 8'hA5, 8'h84};
        send_bytes(fb);
        in_valid = 1'b0;
        wait_frame();
        check("syncdata_ok", frame_ok, 1);
        check("syncdata_nwr", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            check("syncdata_a1", wa[1], 8'h31);
            check("syncdata_d1", wd[1], 8'hA5);
        end

        // Backpressure: full-depth frame ending exactly at table end, next frame held on the bus
        @(negedge cfg_clk);
        wa.delete(); wd.delete();
        stall_cnt = 0;
        fb = '{8'hA5, 8'h90, 8'h10};
        for (int i = 0; i < 16; i++) fb.push_back(8'(i));
        fb.push_back(8'hE8);
        send_bytes(fb);
        send_byte(8'hA5);
        check("bp_stalls", 32'(stall_cnt), 17);
        fb = '{8'h10, 8'h00, 8'hF0};
        send_bytes(fb);
        in_valid = 1'b0;
        wait_frame();
        check("bp_next_ok", frame_ok, 1);
        check("bp_nwr", 32'(wa.size()), 16);
        if (wa.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("bp_addr", wa[i], 8'(8'h90 + i));
                check("bp_data", wd[i], 8'(i));
            end
        end

        // Reset during the second strobe
        @(negedge cfg_clk);
        @(negedge cfg_clk);
        snap_ok  = ok_cnt;
        snap_err = err_cnt;
        fb = '{8'hA5, 8'h40, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_bytes(fb);
        send_byte(8'h8C);
        in_valid = 1'b0;
        @(negedge cfg_clk);
        check("rstc_we2", cfg_we, 1);
        check("rstc_addr2", cfg_addr, 8'h41);
        check("rstc_data2", cfg_wdata, 8'hBB);
        cfg_rst_n = 1'b0;
        #1;
        check("rstc_we_async", cfg_we, 0);
        check("rstc_busy_async", busy, 0);
        check("rstc_rdy_async", in_ready, 0);
        repeat (3) @(negedge cfg_clk);
        cfg_rst_n = 1'b1;
        n = wa.size();
        repeat (5) @(negedge cfg_clk);
        check("rstc_no_more_wr", 32'(wa.size()), 32'(n));
        check("rstc_no_ok", 32'(ok_cnt), 32'(snap_ok));
        check("rstc_no_err", 32'(err_cnt), 32'(snap_err));
        check("rstc_idle_rdy", in_ready, 1);
        check("rstc_idle_busy", busy, 0);

        // Recovery after reset
        wa.delete(); wd.delete();
        fb = '{8'hA5, 8'h05, 8'h02, 8'hAB, 8'hCD, 8'h81};
        send_bytes(fb);
        in_valid = 1'b0;
        wait_frame();
        check("recover_ok", frame_ok, 1);
        check("recover_nwr", 32'(wa.size()), 2);

        repeat (2) @(negedge cfg_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
